// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the small per-size helpers used when launching a memory access.
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  function automatic logic funct3_legal(input logic [2:0] f);
    return f inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU};
  endfunction

  function automatic logic is_aligned(input logic [2:0] f, input logic [1:0] off);
    case (f)
      LSU_H, LSU_HU: return ~off[0];
      LSU_W:         return off == 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f, input logic [1:0] off);
    case (f)
      LSU_B, LSU_BU: return 4'b0001 << off;
      LSU_H, LSU_HU: return 4'b0011 << off;
      default:       return 4'b1111;
    endcase
  endfunction

  // Replicating the low bytes across all lanes lets the byte enables alone
  // select where the store lands.
  function automatic logic [31:0] lane_replicate(input logic [2:0] f, input logic [31:0] w);
    case (f)
      LSU_B, LSU_BU: return {4{w[7:0]}};
      LSU_H, LSU_HU: return {2{w[15:0]}};
      default:       return w;
    endcase
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load formatter: moves the addressed byte/half/word down to
// bit 0 and sign- or zero-extends it for register write-back.
module load_align_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      LSU_B:   result = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   result = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  result = {24'h0, shifted[7:0]};
      LSU_HU:  result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/acknowledge transaction at a time on the
// data-memory port, with misaligned or illegal accesses trapped up front.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_store,
  input  logic [2:0]              req_funct3,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  lsu_state_e state_q, state_d;
  logic [2:0] funct3_q, funct3_d;
  logic [1:0] offset_q, offset_d;
  logic       store_q, store_d;

  logic                    req_ready_q, req_ready_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH/8-1:0] mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] load_result;

  load_align_extend u_align (
    .rdata   (mem_rdata),
    .addr_lo (offset_q),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    store_d     = store_q;
    req_ready_d = req_ready_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d    = req_funct3;
          offset_d    = req_addr[1:0];
          store_d     = req_store;
          req_ready_d = 1'b0;
          if (funct3_legal(req_funct3) && is_aligned(req_funct3, req_addr[1:0])) begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_store;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = byte_enables(req_funct3, req_addr[1:0]);
            mem_wdata_d = lane_replicate(req_funct3, req_wdata);
          end else begin
            // Trapped accesses skip the memory port entirely.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = store_q ? '0 : load_result;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      funct3_q    <= LSU_W;
      offset_q    <= 2'b00;
      store_q     <= 1'b0;
      req_ready_q <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      store_q     <= store_d;
      req_ready_q <= req_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized accesses
// against a byte-level reference model, reset and back-to-back sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Reference model: byte arithmetic on access size and offset.
  function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd, input int wc);
    vec_t v;
    int sz, off;
    longint mask, val;
    sz = size_of(f3);
    off = int'(addr % 4);
    v.store = st; v.f3 = f3; v.addr = addr; v.wdata = wd; v.rdata = rd; v.wait_cycles = wc;
    v.exp_err = (sz == 0) || ((addr % sz) != 0);
    v.exp_be = 4'h0;
    v.exp_wdata = 32'h0;
    v.exp_rdata = 32'h0;
    if (!v.exp_err) begin
      v.exp_be = 4'(((1 << sz) - 1) << off);
      for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
      if (!st) begin
        mask = (64'd1 << (8*sz)) - 1;
        val = longint'(rd >> (8*off)) & mask;
        if ((f3 == 3'b000 || f3 == 3'b001) && val[8*sz-1]) val = val | ~mask;
        v.exp_rdata = val[31:0];
      end
    end
    return v;
  endfunction

  // Runs one transaction from IDLE (called at posedge+1) and checks it.
  task automatic exercise(input vec_t v, input string tag);
    int lat, reqcyc;
    logic got, seen, s_we, r_err;
    logic [31:0] s_addr, s_wdata, r_rdata;
    logic [3:0] s_be;
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    mem_ready = 1'b0; mem_rdata = v.rdata;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; reqcyc = 0; got = 0; seen = 0; r_err = 0; r_rdata = 0;
    s_we = 0; s_addr = 0; s_wdata = 0; s_be = 0;
    for (int k = 1; k <= 24 && !got; k++) begin
      if (mem_req) begin
        if (!seen) begin
          s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wdata = mem_wdata; seen = 1;
        end
        reqcyc++;
        mem_ready = (reqcyc > v.wait_cycles);
      end else begin
        mem_ready = 1'b0;
      end
      if (rsp_valid) begin
        got = 1; lat = k; r_rdata = rsp_rdata; r_err = rsp_err;
      end
      if (!got) begin @(posedge clk); #1; end
    end
    mem_ready = 1'b0;
    check({tag, " response seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'(2 + v.wait_cycles));
    check({tag, " rsp_err"}, 32'(r_err), 32'(v.exp_err));
    check({tag, " rsp_rdata"}, r_rdata, v.exp_err ? 32'h0 : v.exp_rdata);
    check({tag, " mem_req cycles"}, 32'(reqcyc), v.exp_err ? 32'd0 : 32'(v.wait_cycles + 1));
    if (!v.exp_err) begin
      check({tag, " mem_addr"}, s_addr, {v.addr[31:2], 2'b00});
      check({tag, " mem_be"}, 32'(s_be), 32'(v.exp_be));
      check({tag, " mem_we"}, 32'(s_we), 32'(v.store));
      if (v.store) check({tag, " mem_wdata"}, s_wdata, v.exp_wdata);
    end
    @(posedge clk); #1;
    check({tag, " back to idle"}, {req_ready, mem_req, rsp_valid, mem_be}, {3'b100, 4'h0});
  endtask

  vec_t tbl[12];
  logic [5:0] rr_seen, mr_seen, rv_seen;
  logic [31:0] a_addr0, a_addr3;
  int rv_count;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         store f3      addr        wdata         rdata        wait rdata_exp     err   be     wdata_exp
    tbl[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'h203, 32'h0,        32'h80123456, 0, 32'hFFFFFF80, 1'b0, 4'h8, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'h203, 32'h0,        32'h80123456, 0, 32'h00000080, 1'b0, 4'h8, 32'h0};
    tbl[3]  = '{1'b1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0,        3, 32'h0,        1'b0, 4'hC, 32'hABCDABCD};
    tbl[4]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0};
    tbl[5]  = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0};
    tbl[6]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h80123456, 0, 32'h00008012, 1'b0, 4'hC, 32'h0};
    tbl[8]  = '{1'b0, 3'b001, 32'h202, 32'h0,        32'h80123456, 2, 32'hFFFF8012, 1'b0, 4'hC, 32'h0};
    tbl[9]  = '{1'b1, 3'b000, 32'h201, 32'h123456A5, 32'h0,        1, 32'h0,        1'b0, 4'h2, 32'hA5A5A5A5};
    tbl[10] = '{1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        0, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D};
    tbl[11] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h00003F00, 0, 32'h0000003F, 1'b0, 4'h2, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {31'h0, req_ready}, 32'd1);
    check("reset mem", {mem_req, mem_we, mem_be, rsp_valid, rsp_err, 24'h0}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) exercise(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a stalled access.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst seq mem_req before", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("rst seq mem_req dropped", 32'(mem_req), 32'd0);
    check("rst seq req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    rv_count = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid) rv_count++;
      @(posedge clk); #1;
    end
    check("rst seq no response", 32'(rv_count), 32'd0);
    exercise(tbl[0], "after reset");

    // Back-to-back with req_valid held high.
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    a_addr0 = 0; a_addr3 = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk); #1;
      if (j == 0) req_addr = 32'h200;
      rr_seen[j] = req_ready; mr_seen[j] = mem_req; rv_seen[j] = rsp_valid;
      if (j == 0) a_addr0 = mem_addr;
      if (j == 3) begin a_addr3 = mem_addr; req_valid = 1'b0; end
    end
    mem_ready = 1'b0;
    check("b2b req_ready", 32'(rr_seen), 32'(6'b100100));
    check("b2b mem_req", 32'(mr_seen), 32'(6'b001001));
    check("b2b rsp_valid", 32'(rv_seen), 32'(6'b010010));
    check("b2b first addr", a_addr0, 32'h100);
    check("b2b second addr", a_addr3, 32'h200);
    @(posedge clk); #1;

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] ad;
      vec_t v;
      f3 = 3'($urandom_range(0, 7));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case (size_of(f3))
          2: ad[0] = 1'b0;
          4: ad[1:0] = 2'b00;
          default: ;
        endcase
      end
      v = model(1'($urandom_range(0, 1)), f3, ad, $urandom, $urandom, $urandom_range(0, 3));
      exercise(v, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
